// File: rtl/jump_motion.sv
// Vertical-motion engine for the player sprite: gravity, multi-jump, ceiling clamp,
// capped fall speed. One motion step per clk whenever start and tick are both high.
module jump_motion #(
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int SPD_W     = 4,
    parameter int X_INIT    = 276,
    parameter int Y_GROUND  = 320,
    parameter int Y_TOP     = 16,
    parameter int MAX_FALL  = 7,
    parameter int MAX_JUMPS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             tick,
    input  logic             jump_req,
    input  logic [SPD_W-1:0] max_speed,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [SPD_W-1:0] speed,
    output logic             direction,
    output logic             airborne,
    output logic             landed,
    output logic [SPD_W-1:0] jumps_used
);

    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

    localparam logic [Y_W-1:0]   YG   = Y_W'(Y_GROUND);
    localparam logic [Y_W-1:0]   YT   = Y_W'(Y_TOP);
    localparam logic [SPD_W-1:0] MAXF = SPD_W'(MAX_FALL);
    localparam logic [SPD_W-1:0] MAXJ = SPD_W'(MAX_JUMPS);

    // Upward move can overshoot past row 0, so it is evaluated signed one bit wider.
    function automatic logic signed [Y_W:0] rise_pos(input logic [Y_W-1:0] yy,
                                                    input logic [SPD_W-1:0] s);
        return $signed({1'b0, yy}) - $signed({{(Y_W+1-SPD_W){1'b0}}, s});
    endfunction

    function automatic logic [Y_W:0] fall_pos(input logic [Y_W-1:0] yy,
                                             input logic [SPD_W-1:0] s);
        return {1'b0, yy} + {{(Y_W+1-SPD_W){1'b0}}, s};
    endfunction

    function automatic logic [SPD_W-1:0] sat_fall(input logic [SPD_W-1:0] s);
        return (s >= MAXF) ? MAXF : s + 1'b1;
    endfunction

    state_t                 state, state_nx;
    logic [Y_W-1:0]         y_nx;
    logic [SPD_W-1:0]       speed_nx, ju_nx;
    logic                   dir_nx, pend, pend_nx, land_p0, land_nx;
    logic                   step, do_jump;
    logic signed [Y_W:0]    rise_y;
    logic [Y_W:0]           fall_y;

    assign x       = X_W'(X_INIT);
    assign step    = start & tick;
    assign do_jump = pend && (jumps_used < MAXJ) && (max_speed != '0);
    assign rise_y  = rise_pos(y, speed);
    assign fall_y  = fall_pos(y, speed);
    // A pending request is spent by any step, whether it launches or is discarded.
    assign pend_nx = jump_req | (pend & ~step);

    always_comb begin
        state_nx = state;
        y_nx     = y;
        speed_nx = speed;
        dir_nx   = direction;
        ju_nx    = jumps_used;
        land_nx  = 1'b0;
        if (step) begin
            if (do_jump) begin
                state_nx = RISE;
                speed_nx = max_speed;
                dir_nx   = 1'b1;
                ju_nx    = jumps_used + 1'b1;
            end else begin
                case (state)
                    GROUND: begin
                        y_nx     = YG;
                        speed_nx = '0;
                        dir_nx   = 1'b0;
                    end
                    RISE: begin
                        if (speed == '0) begin
                            state_nx = FALL;
                            dir_nx   = 1'b0;
                        end else if (rise_y < $signed({1'b0, YT})) begin
                            y_nx     = YT;
                            speed_nx = '0;
                            state_nx = FALL;
                            dir_nx   = 1'b0;
                        end else begin
                            y_nx     = rise_y[Y_W-1:0];
                            speed_nx = speed - 1'b1;
                        end
                    end
                    FALL: begin
                        if (fall_y >= {1'b0, YG}) begin
                            y_nx     = YG;
                            speed_nx = '0;
                            ju_nx    = '0;
                            state_nx = GROUND;
                            land_nx  = 1'b1;
                        end else begin
                            y_nx     = fall_y[Y_W-1:0];
                            speed_nx = sat_fall(speed);
                        end
                    end
                    default: state_nx = GROUND;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= GROUND;
            y          <= YG;
            speed      <= '0;
            direction  <= 1'b0;
            jumps_used <= '0;
            airborne   <= 1'b0;
            pend       <= 1'b0;
            land_p0    <= 1'b0;
            landed     <= 1'b0;
        end else begin
            state      <= state_nx;
            y          <= y_nx;
            speed      <= speed_nx;
            direction  <= dir_nx;
            jumps_used <= ju_nx;
            airborne   <= (state_nx != GROUND);
            pend       <= pend_nx;
            // landing step registered here, surfaced on landed one clk later
            land_p0    <= land_nx;
            landed     <= land_p0;
        end
    end

endmodule

// File: tb/tb_jump_motion.sv
// Scoreboard bench for jump_motion: directed rows push expectations, monitors compare
// each DUT one clk later. A second instance uses a lowered ceiling.
module tb_jump_motion;

    typedef struct packed {
        logic [8:0] y;
        logic [3:0] spd;
        logic       dir;
        logic       air;
        logic [3:0] ju;
        logic       lnd;
    } obs_t;

    typedef struct {
        int   tn;
        obs_t o;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b1;
    logic       tick = 1'b1;
    logic       jump_req = 1'b0;
    logic [3:0] max_speed = 4'd7;

    logic [9:0] x1, x2;
    logic [8:0] y1, y2;
    logic [3:0] sp1, sp2, ju1, ju2;
    logic       dir1, dir2, air1, air2, lnd1, lnd2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tnum = 0;
    int   target = 0;
    logic run_s = 1'b1;
    logic run_t = 1'b1;
    logic [3:0] ms_v = 4'd7;

    always #5 clk = ~clk;

    jump_motion dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .jump_req(jump_req),
        .max_speed(max_speed), .x(x1), .y(y1), .speed(sp1), .direction(dir1),
        .airborne(air1), .landed(lnd1), .jumps_used(ju1)
    );

    jump_motion #(.Y_TOP(300)) dut_top (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .jump_req(jump_req),
        .max_speed(max_speed), .x(x2), .y(y2), .speed(sp2), .direction(dir2),
        .airborne(air2), .landed(lnd2), .jumps_used(ju2)
    );

    task automatic check(input int tn, input int which, input obs_t e, input obs_t a,
                         input logic [9:0] ax);
        n_cmp++;
        if (a !== e || ax !== 10'd276) begin
            n_bad++;
            $display("FAIL t%0d dut%0d: got y=%0d spd=%0d dir=%0d air=%0d ju=%0d lnd=%0d x=%0d; expected y=%0d spd=%0d dir=%0d air=%0d ju=%0d lnd=%0d x=276",
                     tn, which, a.y, a.spd, a.dir, a.air, a.ju, a.lnd, ax,
                     e.y, e.spd, e.dir, e.air, e.ju, e.lnd);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q1.size() > 0) begin
            m1 = q1.pop_front();
            check(m1.tn, 1, m1.o, '{y: y1, spd: sp1, dir: dir1, air: air1, ju: ju1, lnd: lnd1}, x1);
        end
        if (q2.size() > 0) begin
            m2 = q2.pop_front();
            check(m2.tn, 2, m2.o, '{y: y2, spd: sp2, dir: dir2, air: air2, ju: ju2, lnd: lnd2}, x2);
        end
    end

    // Drive one clk of stimulus; the expectation applies after the following posedge.
    task automatic row(input logic j, input int ey, input int es, input int ed,
                       input int ea, input int eju, input int el);
        exp_t e;
        @(negedge clk);
        start     = run_s;
        tick      = run_t;
        jump_req  = j;
        max_speed = ms_v;
        e.tn = tnum;
        e.o  = '{y: 9'(ey), spd: 4'(es), dir: ed[0], air: ea[0], ju: 4'(eju), lnd: el[0]};
        if (target == 0) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        jump_req = 1'b0;
        start = 1'b1;
        tick = 1'b1;
        run_s = 1'b1;
        run_t = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rise7[7];
        int fall7[7];
        int rise15[15];
        int fall15[7];
        rise7  = '{313, 307, 302, 298, 295, 293, 292};
        fall7  = '{292, 293, 295, 298, 302, 307, 313};
        rise15 = '{305, 291, 278, 266, 255, 245, 236, 228, 221, 215, 210, 206, 203, 201, 200};
        fall15 = '{200, 201, 203, 206, 210, 215, 221};

        // Test 1: idle on the ground
        tnum = 1;
        do_reset();
        for (int i = 0; i < 50; i++) row(1'b0, 320, 0, 0, 0, 0, 0);

        // Test 2: single jump, full arc
        tnum = 2;
        do_reset();
        ms_v = 4'd7;
        row(1'b1, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 7, 1, 1, 1, 0);
        for (int i = 0; i < 7; i++) row(1'b0, rise7[i], 6 - i, 1, 1, 1, 0);
        row(1'b0, 292, 0, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) row(1'b0, fall7[i], i + 1, 0, 1, 1, 0);
        row(1'b0, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 0, 0, 0, 0, 1);
        row(1'b0, 320, 0, 0, 0, 0, 0);

        // Test 3: double jump at apex, third request discarded
        tnum = 3;
        do_reset();
        row(1'b1, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 7, 1, 1, 1, 0);
        for (int i = 0; i < 6; i++) row(1'b0, rise7[i], 6 - i, 1, 1, 1, 0);
        row(1'b1, 292, 0, 1, 1, 1, 0);
        row(1'b0, 292, 7, 1, 1, 2, 0);
        row(1'b0, 285, 6, 1, 1, 2, 0);
        row(1'b1, 279, 5, 1, 1, 2, 0);
        row(1'b0, 274, 4, 1, 1, 2, 0);
        row(1'b0, 270, 3, 1, 1, 2, 0);
        row(1'b0, 267, 2, 1, 1, 2, 0);
        row(1'b0, 265, 1, 1, 1, 2, 0);
        row(1'b0, 264, 0, 1, 1, 2, 0);
        row(1'b0, 264, 0, 0, 1, 2, 0);
        row(1'b0, 264, 1, 0, 1, 2, 0);
        row(1'b0, 265, 2, 0, 1, 2, 0);
        row(1'b0, 267, 3, 0, 1, 2, 0);
        row(1'b0, 270, 4, 0, 1, 2, 0);
        row(1'b0, 274, 5, 0, 1, 2, 0);
        row(1'b0, 279, 6, 0, 1, 2, 0);
        row(1'b0, 285, 7, 0, 1, 2, 0);
        row(1'b0, 292, 7, 0, 1, 2, 0);
        row(1'b0, 299, 7, 0, 1, 2, 0);
        row(1'b0, 306, 7, 0, 1, 2, 0);
        row(1'b0, 313, 7, 0, 1, 2, 0);
        row(1'b0, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 0, 0, 0, 0, 1);

        // Test 4: ceiling clamp on the Y_TOP=300 instance
        tnum = 4;
        target = 1;
        do_reset();
        row(1'b1, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 7, 1, 1, 1, 0);
        row(1'b0, 313, 6, 1, 1, 1, 0);
        row(1'b0, 307, 5, 1, 1, 1, 0);
        row(1'b0, 302, 4, 1, 1, 1, 0);
        row(1'b0, 300, 0, 0, 1, 1, 0);
        row(1'b0, 300, 1, 0, 1, 1, 0);
        row(1'b0, 301, 2, 0, 1, 1, 0);
        row(1'b0, 303, 3, 0, 1, 1, 0);
        row(1'b0, 306, 4, 0, 1, 1, 0);
        row(1'b0, 310, 5, 0, 1, 1, 0);
        row(1'b0, 315, 6, 0, 1, 1, 0);
        row(1'b0, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 0, 0, 0, 0, 1);
        target = 0;

        // Test 5: freeze mid-air, held request, then asynchronous reset in flight
        tnum = 5;
        do_reset();
        row(1'b1, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 7, 1, 1, 1, 0);
        row(1'b0, 313, 6, 1, 1, 1, 0);
        run_s = 1'b0;
        for (int i = 0; i < 5; i++) row(i == 2, 313, 6, 1, 1, 1, 0);
        run_s = 1'b1;
        run_t = 1'b0;
        for (int i = 0; i < 5; i++) row(1'b0, 313, 6, 1, 1, 1, 0);
        run_t = 1'b1;
        row(1'b0, 313, 7, 1, 1, 2, 0);
        row(1'b0, 306, 6, 1, 1, 2, 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check(5, 1, '{y: 9'd320, spd: 4'd0, dir: 1'b0, air: 1'b0, ju: 4'd0, lnd: 1'b0},
              '{y: y1, spd: sp1, dir: dir1, air: air1, ju: ju1, lnd: lnd1}, x1);
        for (int i = 0; i < 3; i++) row(1'b0, 320, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) row(1'b0, 320, 0, 0, 0, 0, 0);

        // Test 6: zero launch speed discards the request; speed 15 saturates the fall
        tnum = 6;
        do_reset();
        ms_v = 4'd0;
        row(1'b1, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 0, 0, 0, 0, 0);
        ms_v = 4'd7;
        row(1'b0, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 0, 0, 0, 0, 0);
        ms_v = 4'd15;
        row(1'b1, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 15, 1, 1, 1, 0);
        for (int i = 0; i < 15; i++) row(1'b0, rise15[i], 14 - i, 1, 1, 1, 0);
        row(1'b0, 200, 0, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) row(1'b0, fall15[i], i + 1, 0, 1, 1, 0);
        for (int yy = 228; yy <= 319; yy += 7) row(1'b0, yy, 7, 0, 1, 1, 0);
        row(1'b0, 320, 0, 0, 0, 0, 0);
        row(1'b0, 320, 0, 0, 0, 0, 1);
        row(1'b0, 320, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", q1.size(), q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
